// File: rtl/fp_misc_pipe.sv
// fp_misc_pipe
// Pipelined non-arithmetic FP unit for the RISC-V F/D extensions. It covers
// move, sign-injection, min/max, compare and classify on one configurable
// format of W = 1+EXP_W+FRAC_W bits, with NaN-boxing when FLEN > W.
// All decode and compute is combinational in front of stage 1. Stages 2..STAGES
// are plain delay registers. The whole pipe advances together whenever the
// output slot is empty or is being consumed.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset
//   in_valid     operation offered
//   in_ready     operation accepted when in_valid && in_ready
//   command      0 Move, 1 Sgnj, 2 Sgnjn, 3 Sgnjx, 4 Min, 5 Max,
//                6 Eq, 7 Lt, 8 Le, 9 Class, 10-15 illegal (all-zero result)
//   int_src1     integer source for Move
//   fp_src1/2    FP sources (NaN-boxed when FLEN > W)
//   out_valid    result present
//   out_ready    result consumed when out_valid && out_ready
//   int_result   integer write-back value
//   fp_result    FP write-back value (always boxed when it is the result)
//   flag_invalid NV exception for this result
module fp_misc_pipe #(
   parameter int XLEN   = 32,
   parameter int FLEN   = 32,
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        command,
   input  logic [XLEN-1:0]   int_src1,
   input  logic [FLEN-1:0]   fp_src1,
   input  logic [FLEN-1:0]   fp_src2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   int_result,
   output logic [FLEN-1:0]   fp_result,
   output logic              flag_invalid
);

   localparam int W = 1 + EXP_W + FRAC_W;

   localparam logic [3:0] CMD_MOVE  = 4'd0;
   localparam logic [3:0] CMD_SGNJ  = 4'd1;
   localparam logic [3:0] CMD_SGNJN = 4'd2;
   localparam logic [3:0] CMD_SGNJX = 4'd3;
   localparam logic [3:0] CMD_MIN   = 4'd4;
   localparam logic [3:0] CMD_MAX   = 4'd5;
   localparam logic [3:0] CMD_EQ    = 4'd6;
   localparam logic [3:0] CMD_LT    = 4'd7;
   localparam logic [3:0] CMD_LE    = 4'd8;
   localparam logic [3:0] CMD_CLASS = 4'd9;

   localparam logic [W-1:0]    CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
   // Expected contents of the operand bits above W once shifted down. This is
   // zero when FLEN == W, so every operand then counts as correctly boxed.
   localparam logic [FLEN-1:0] BOX_ONES  = {FLEN{1'b1}} >> W;

   // An operand whose upper bits are not all ones is not a valid narrow value
   // and is replaced by the canonical quiet NaN.
   function automatic logic [W-1:0] unbox(input logic [FLEN-1:0] x);
      logic [FLEN-1:0] upper;
      upper = x >> W;
      if (upper != BOX_ONES) begin
         return CANON_NAN;
      end
      return x[W-1:0];
   endfunction

   function automatic logic [FLEN-1:0] box(input logic [W-1:0] v);
      logic [FLEN-1:0] r;
      r = '1;
      r[W-1:0] = v;
      return r;
   endfunction

   logic [W-1:0]      w_a;
   logic [W-1:0]      w_b;
   logic              w_aSign, w_bSign;
   logic [EXP_W-1:0]  w_aExp, w_bExp;
   logic [FRAC_W-1:0] w_aFrac, w_bFrac;
   logic [W-2:0]      w_aMag, w_bMag;
   logic              w_aExpOnes, w_aExpZero, w_aFracZero;
   logic              w_bExpOnes, w_bExpZero, w_bFracZero;
   logic              w_aNaN, w_aSNaN, w_aInf, w_aZero, w_aSub, w_aNorm;
   logic              w_bNaN, w_bSNaN, w_bZero;
   logic              w_aLtTotal, w_bothZero, w_ordLt, w_ordEq;
   logic [9:0]        w_class;
   logic [W-1:0]      w_minVal, w_maxVal;
   logic [XLEN-1:0]   w_int;
   logic [FLEN-1:0]   w_fp;
   logic              w_flag;
   logic              w_advance;
   logic              w_unusedBits;

   assign w_unusedBits = ^(int_src1 >> W);

   // Split the unboxed operands into fields and derive the category of each.
   // Only operand a is ever classified, so b needs just NaN/zero/sign info.
   always_comb begin
      w_a         = unbox(fp_src1);
      w_b         = unbox(fp_src2);
      w_aSign     = w_a[W-1];
      w_bSign     = w_b[W-1];
      w_aExp      = w_a[W-2:FRAC_W];
      w_bExp      = w_b[W-2:FRAC_W];
      w_aFrac     = w_a[FRAC_W-1:0];
      w_bFrac     = w_b[FRAC_W-1:0];
      w_aMag      = w_a[W-2:0];
      w_bMag      = w_b[W-2:0];
      w_aExpOnes  = &w_aExp;
      w_aExpZero  = ~|w_aExp;
      w_aFracZero = ~|w_aFrac;
      w_bExpOnes  = &w_bExp;
      w_bExpZero  = ~|w_bExp;
      w_bFracZero = ~|w_bFrac;
      w_aNaN      = w_aExpOnes & ~w_aFracZero;
      w_aSNaN     = w_aNaN & ~w_aFrac[FRAC_W-1];
      w_aInf      = w_aExpOnes & w_aFracZero;
      w_aZero     = w_aExpZero & w_aFracZero;
      w_aSub      = w_aExpZero & ~w_aFracZero;
      w_aNorm     = ~w_aExpOnes & ~w_aExpZero;
      w_bNaN      = w_bExpOnes & ~w_bFracZero;
      w_bSNaN     = w_bNaN & ~w_bFrac[FRAC_W-1];
      w_bZero     = w_bExpZero & w_bFracZero;
   end

   // Ordering of two non-NaN values. The "total" form puts -0 below +0, which
   // is what min/max needs. Compares treat the two zeros as equal instead.
   // Sign-magnitude order flips for negative numbers.
   always_comb begin
      if (w_aSign != w_bSign) begin
         w_aLtTotal = w_aSign;
      end else if (w_aSign) begin
         w_aLtTotal = w_aMag > w_bMag;
      end else begin
         w_aLtTotal = w_aMag < w_bMag;
      end
      w_bothZero = w_aZero & w_bZero;
      w_ordLt    = w_aLtTotal & ~w_bothZero;
      w_ordEq    = (w_a == w_b) | w_bothZero;
   end

   // Min/max: a single NaN loses to the other operand. Two NaNs collapse to
   // the canonical quiet NaN.
   always_comb begin
      if (w_aNaN && w_bNaN) begin
         w_minVal = CANON_NAN;
         w_maxVal = CANON_NAN;
      end else if (w_aNaN) begin
         w_minVal = w_b;
         w_maxVal = w_b;
      end else if (w_bNaN) begin
         w_minVal = w_a;
         w_maxVal = w_a;
      end else begin
         w_minVal = w_aLtTotal ? w_a : w_b;
         w_maxVal = w_aLtTotal ? w_b : w_a;
      end
   end

   // One-hot fclass encoding, bit 0 is -inf through bit 9 quiet NaN.
   always_comb begin
      w_class    = '0;
      w_class[0] = w_aSign & w_aInf;
      w_class[1] = w_aSign & w_aNorm;
      w_class[2] = w_aSign & w_aSub;
      w_class[3] = w_aSign & w_aZero;
      w_class[4] = ~w_aSign & w_aZero;
      w_class[5] = ~w_aSign & w_aSub;
      w_class[6] = ~w_aSign & w_aNorm;
      w_class[7] = ~w_aSign & w_aInf;
      w_class[8] = w_aSNaN;
      w_class[9] = w_aNaN & ~w_aSNaN;
   end

   // Result select. Whichever write-back port a command does not use stays
   // zero. Illegal commands fall through to the all-zero default.
   always_comb begin
      w_int  = '0;
      w_fp   = '0;
      w_flag = 1'b0;
      case (command)
         CMD_MOVE: begin
            w_int          = {XLEN{fp_src1[W-1]}};
            w_int[W-1:0]   = fp_src1[W-1:0];
            w_fp           = box(int_src1[W-1:0]);
         end
         CMD_SGNJ:  w_fp = box({w_bSign, w_a[W-2:0]});
         CMD_SGNJN: w_fp = box({~w_bSign, w_a[W-2:0]});
         CMD_SGNJX: w_fp = box({w_aSign ^ w_bSign, w_a[W-2:0]});
         CMD_MIN: begin
            w_fp   = box(w_minVal);
            w_flag = w_aSNaN | w_bSNaN;
         end
         CMD_MAX: begin
            w_fp   = box(w_maxVal);
            w_flag = w_aSNaN | w_bSNaN;
         end
         CMD_EQ: begin
            w_int[0] = ~w_aNaN & ~w_bNaN & w_ordEq;
            w_flag   = w_aSNaN | w_bSNaN;
         end
         CMD_LT: begin
            w_int[0] = ~w_aNaN & ~w_bNaN & w_ordLt;
            w_flag   = w_aNaN | w_bNaN;
         end
         CMD_LE: begin
            w_int[0] = ~w_aNaN & ~w_bNaN & (w_ordLt | w_ordEq);
            w_flag   = w_aNaN | w_bNaN;
         end
         CMD_CLASS: w_int[9:0] = w_class;
         default: begin
            w_int  = '0;
            w_fp   = '0;
            w_flag = 1'b0;
         end
      endcase
   end

   logic            r_valid [STAGES];
   logic [XLEN-1:0] r_int   [STAGES];
   logic [FLEN-1:0] r_fp    [STAGES];
   logic            r_flag  [STAGES];

   // The pipe moves as a single unit: it only stalls when the last stage holds
   // a result nobody is taking.
   assign w_advance = ~(r_valid[STAGES-1] & ~out_ready);
   assign in_ready  = w_advance;

   // Stage registers. Reset wipes everything so in-flight work vanishes and the
   // outputs read zero. On an advance, stage 1 captures the computed result (or
   // zeros for a bubble) and every later stage takes its predecessor. With no
   // advance, every stage holds, which keeps the outputs bit-stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            r_valid[s] <= 1'b0;
            r_int[s]   <= '0;
            r_fp[s]    <= '0;
            r_flag[s]  <= 1'b0;
         end
      end else if (w_advance) begin
         r_valid[0] <= in_valid;
         r_int[0]   <= in_valid ? w_int  : '0;
         r_fp[0]    <= in_valid ? w_fp   : '0;
         r_flag[0]  <= in_valid ? w_flag : 1'b0;
         for (int s = 1; s < STAGES; s++) begin
            r_valid[s] <= r_valid[s-1];
            r_int[s]   <= r_int[s-1];
            r_fp[s]    <= r_fp[s-1];
            r_flag[s]  <= r_flag[s-1];
         end
      end
   end

   assign out_valid    = r_valid[STAGES-1];
   assign int_result   = r_int[STAGES-1];
   assign fp_result    = r_fp[STAGES-1];
   assign flag_invalid = r_flag[STAGES-1];

endmodule

// File: tb/tb_fp_misc_pipe.sv
// tb_fp_misc_pipe
// Self-checking bench for fp_misc_pipe configured as single precision inside
// 64-bit registers (XLEN=FLEN=64, W=32, STAGES=3). A scoreboard queue holds
// the expected result of every accepted op. The expected results come from a
// reference model that evaluates operands as real numbers.
module tb_fp_misc_pipe;

   localparam int XLEN   = 64;
   localparam int FLEN   = 64;
   localparam int STAGES = 3;
   localparam logic [31:0] BOXHI = 32'hFFFFFFFF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        command = 4'd0;
   logic [XLEN-1:0]   int_src1 = '0;
   logic [FLEN-1:0]   fp_src1 = '0;
   logic [FLEN-1:0]   fp_src2 = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [XLEN-1:0]   int_result;
   logic [FLEN-1:0]   fp_result;
   logic              flag_invalid;

   fp_misc_pipe #(
      .XLEN(XLEN), .FLEN(FLEN), .EXP_W(8), .FRAC_W(23), .STAGES(STAGES)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .command(command), .int_src1(int_src1), .fp_src1(fp_src1), .fp_src2(fp_src2),
      .out_valid(out_valid), .out_ready(out_ready), .int_result(int_result),
      .fp_result(fp_result), .flag_invalid(flag_invalid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] intRes;
      logic [63:0] fpRes;
      logic        flag;
   } result_t;

   result_t expQ[$];
   int      consumeTimes[$];
   int      checkCount = 0;
   int      errorCount = 0;
   int      cycleCount = 0;
   int      acceptCount = 0;
   int      consumeCount = 0;
   int      notReadyCount = 0;
   logic    prevStalled = 1'b0;
   logic [63:0] heldInt, heldFp;
   logic    heldFlag;

   logic [31:0] specials [12] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                  32'h7FC00000, 32'h7F800001, 32'hFFC00000, 32'h3F800000,
                                  32'hBF800000, 32'h00000001, 32'h807FFFFF, 32'h3F800001};

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
      end
   endtask

   task automatic reportTimeout(input string tag);
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s: timed out waiting on the DUT", tag);
   endtask

   // ---------------- reference model ----------------
   function automatic real pow2(input int k);
      real r;
      r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else        for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic logic [31:0] unboxV(input logic [63:0] x);
      return (x[63:32] == BOXHI) ? x[31:0] : 32'h7FC00000;
   endfunction

   function automatic logic isNaN(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic logic isSNaN(input logic [31:0] v);
      return isNaN(v) && !v[22];
   endfunction

   // Value of a non-NaN single as a real. Infinity is stood in for by a value
   // far beyond the largest finite single, which keeps orderings correct.
   function automatic real toReal(input logic [31:0] v);
      real mag;
      if (v[30:23] == 8'hFF)      mag = 1.0e300;
      else if (v[30:23] == 8'h00) mag = real'(v[22:0]) * pow2(-149);
      else                        mag = real'({1'b1, v[22:0]}) * pow2(int'(v[30:23]) - 150);
      return v[31] ? -mag : mag;
   endfunction

   function automatic result_t model(input logic [3:0] cmd, input logic [63:0] s1,
                                     input logic [63:0] s2, input logic [63:0] i1);
      result_t r;
      logic [31:0] a, b, m;
      logic aN, bN, aS, bS;
      real ra, rb;
      int idx;
      r  = '0;
      a  = unboxV(s1);
      b  = unboxV(s2);
      aN = isNaN(a);  bN = isNaN(b);
      aS = isSNaN(a); bS = isSNaN(b);
      ra = aN ? 0.0 : toReal(a);
      rb = bN ? 0.0 : toReal(b);
      m  = 32'd0;
      idx = 0;
      case (cmd)
         4'd0: begin
            r.intRes = {{32{s1[31]}}, s1[31:0]};
            r.fpRes  = {BOXHI, i1[31:0]};
         end
         4'd1: r.fpRes = {BOXHI, b[31], a[30:0]};
         4'd2: r.fpRes = {BOXHI, ~b[31], a[30:0]};
         4'd3: r.fpRes = {BOXHI, a[31] ^ b[31], a[30:0]};
         4'd4, 4'd5: begin
            if (aN && bN)                   m = 32'h7FC00000;
            else if (aN)                    m = b;
            else if (bN)                    m = a;
            else if (ra == 0.0 && rb == 0.0) m = ((cmd == 4'd4) == a[31]) ? a : b;
            else if (cmd == 4'd4)           m = (ra < rb) ? a : b;
            else                            m = (ra > rb) ? a : b;
            r.fpRes = {BOXHI, m};
            r.flag  = aS || bS;
         end
         4'd6: begin
            r.intRes = {63'd0, !aN && !bN && (ra == rb)};
            r.flag   = aS || bS;
         end
         4'd7: begin
            r.intRes = {63'd0, !aN && !bN && (ra < rb)};
            r.flag   = aN || bN;
         end
         4'd8: begin
            r.intRes = {63'd0, !aN && !bN && (ra <= rb)};
            r.flag   = aN || bN;
         end
         4'd9: begin
            if (aN)                      idx = aS ? 8 : 9;
            else if (a[30:23] == 8'hFF)  idx = a[31] ? 0 : 7;
            else if (ra == 0.0)          idx = a[31] ? 3 : 4;
            else if (a[30:23] == 8'h00)  idx = a[31] ? 2 : 5;
            else                         idx = a[31] ? 1 : 6;
            r.intRes = 64'd1 << idx;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // ---------------- cycle counter and monitor ----------------
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Sampled mid-cycle: checks hold-stability under stall, the ready rule, the
   // scoreboard on every consumed result, and records every accepted op.
   always @(negedge clk) begin
      result_t e;
      if (prevStalled) begin
         checkOutput("stallValid", {63'd0, out_valid}, 64'd1);
         checkOutput("stallInt", int_result, heldInt);
         checkOutput("stallFp", fp_result, heldFp);
         checkOutput("stallFlag", {63'd0, flag_invalid}, {63'd0, heldFlag});
      end
      checkOutput("inReady", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (in_valid && !in_ready) notReadyCount++;
      if (rst) begin
         expQ.delete();
      end else begin
         if (out_valid && out_ready) begin
            consumeCount++;
            consumeTimes.push_back(cycleCount);
            if (expQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL unexpectedOutput: got int 0x%h fp 0x%h, expected no result", int_result, fp_result);
            end else begin
               e = expQ.pop_front();
               checkOutput("sbInt", int_result, e.intRes);
               checkOutput("sbFp", fp_result, e.fpRes);
               checkOutput("sbFlag", {63'd0, flag_invalid}, {63'd0, e.flag});
            end
         end
         if (in_valid && in_ready) begin
            acceptCount++;
            expQ.push_back(model(command, fp_src1, fp_src2, int_src1));
         end
      end
      prevStalled = !rst && out_valid && !out_ready;
      heldInt  = int_result;
      heldFp   = fp_result;
      heldFlag = flag_invalid;
   end

   // ---------------- stimulus ----------------
   // Offers one op and returns #1 after the edge that accepted it, leaving
   // in_valid high so the caller can stream back-to-back.
   task automatic applyStimulus(input logic [3:0] cmd, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] i);
      logic ok;
      command  = cmd;
      fp_src1  = a;
      fp_src2  = b;
      int_src1 = i;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready && !rst;
         @(posedge clk);
         #1;
      end
      if (!ok) reportTimeout("accept");
   endtask

   task automatic runDirected(input string tag, input logic [3:0] cmd, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] i, input logic [63:0] expInt,
                              input logic [63:0] expFp, input logic expFlag);
      int k;
      applyStimulus(cmd, a, b, i);
      in_valid = 1'b0;
      for (k = 0; k < 20 && !out_valid; k++) begin
         @(posedge clk);
         #1;
      end
      if (!out_valid) begin
         reportTimeout({tag, " result"});
      end else begin
         checkOutput({tag, " latency"}, 64'(k), 64'(STAGES - 1));
         checkOutput({tag, " int"}, int_result, expInt);
         checkOutput({tag, " fp"}, fp_result, expFp);
         checkOutput({tag, " flag"}, {63'd0, flag_invalid}, {63'd0, expFlag});
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] randOperand();
      logic [31:0] v;
      int pick;
      pick = $urandom_range(0, 15);
      v = (pick < 12) ? specials[pick] : $urandom;
      if ($urandom_range(0, 7) == 0) return {$urandom, v};
      return {BOXHI, v};
   endfunction

   task automatic drain(input string tag);
      for (int k = 0; k < 200 && expQ.size() != 0; k++) @(posedge clk);
      #1;
      if (expQ.size() != 0) reportTimeout(tag);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      logic doneRand;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("resetValid", {63'd0, out_valid}, 64'd0);
      checkOutput("resetInt", int_result, 64'd0);
      checkOutput("resetFp", fp_result, 64'd0);
      checkOutput("resetFlag", {63'd0, flag_invalid}, 64'd0);
      checkOutput("resetReady", {63'd0, in_ready}, 64'd1);

      $display("[TB] directed operations");
      runDirected("sgnjn", 4'd2, {BOXHI, 32'h3F800000}, {BOXHI, 32'h3F800000}, 64'd0, 64'd0, {BOXHI, 32'hBF800000}, 1'b0);
      runDirected("minZero", 4'd4, {BOXHI, 32'h80000000}, {BOXHI, 32'h00000000}, 64'd0, 64'd0, {BOXHI, 32'h80000000}, 1'b0);
      runDirected("maxSNaN", 4'd5, {BOXHI, 32'h7F800001}, {BOXHI, 32'h3F800000}, 64'd0, 64'd0, {BOXHI, 32'h3F800000}, 1'b1);
      runDirected("minQNaN", 4'd4, {BOXHI, 32'h7FC00001}, {BOXHI, 32'hFFC00000}, 64'd0, 64'd0, {BOXHI, 32'h7FC00000}, 1'b0);
      runDirected("ltQNaN", 4'd7, {BOXHI, 32'h7FC00000}, {BOXHI, 32'h3F800000}, 64'd0, 64'd0, 64'd0, 1'b1);
      runDirected("eqQNaN", 4'd6, {BOXHI, 32'h7FC00000}, {BOXHI, 32'h3F800000}, 64'd0, 64'd0, 64'd0, 1'b0);
      runDirected("leZero", 4'd8, {BOXHI, 32'h80000000}, {BOXHI, 32'h00000000}, 64'd0, 64'd1, 64'd0, 1'b0);
      runDirected("classNegInf", 4'd9, {BOXHI, 32'hFF800000}, 64'd0, 64'd0, 64'h001, 64'd0, 1'b0);
      runDirected("classSub", 4'd9, {BOXHI, 32'h00000001}, 64'd0, 64'd0, 64'h020, 64'd0, 1'b0);
      runDirected("classSNaN", 4'd9, {BOXHI, 32'h7F800001}, 64'd0, 64'd0, 64'h100, 64'd0, 1'b0);
      runDirected("classBadBox", 4'd9, 64'h00000000_3F800000, 64'd0, 64'd0, 64'h200, 64'd0, 1'b0);
      runDirected("move", 4'd0, {BOXHI, 32'hC0000000}, 64'd0, 64'h40490FDB, 64'hFFFFFFFF_C0000000, 64'hFFFFFFFF_40490FDB, 1'b0);
      runDirected("illegal", 4'd12, {BOXHI, 32'h3F800000}, {BOXHI, 32'hBF800000}, 64'd5, 64'd0, 64'd0, 1'b0);

      $display("[TB] backpressure with out_ready held low");
      base = acceptCount;
      notReadyCount = 0;
      out_ready = 1'b0;
      fork
         begin
            for (int n = 0; n < 6; n++) applyStimulus(4'($urandom_range(0, 9)), randOperand(), randOperand(), {$urandom, $urandom});
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain("bpDrain");
      checkOutput("bpInReadyDrop", {63'd0, notReadyCount > 0}, 64'd1);
      checkOutput("bpAccepted", 64'(acceptCount - base), 64'd6);

      $display("[TB] streaming with simultaneous issue and consume");
      base = consumeCount;
      notReadyCount = 0;
      consumeTimes.delete();
      for (int n = 0; n < 8; n++) applyStimulus(4'($urandom_range(0, 9)), randOperand(), randOperand(), {$urandom, $urandom});
      in_valid = 1'b0;
      drain("streamDrain");
      checkOutput("streamNoStall", 64'(notReadyCount), 64'd0);
      checkOutput("streamConsumed", 64'(consumeCount - base), 64'd8);
      if (consumeTimes.size() == 8)
         checkOutput("streamOnePerCycle", 64'(consumeTimes[7] - consumeTimes[0]), 64'd7);
      else
         checkOutput("streamCount", 64'(consumeTimes.size()), 64'd8);

      $display("[TB] reset with ops in flight");
      out_ready = 1'b1;
      base = consumeCount;
      applyStimulus(4'd1, {BOXHI, 32'h3F800000}, {BOXHI, 32'hBF800000}, 64'd0);
      applyStimulus(4'd9, {BOXHI, 32'h00000000}, 64'd0, 64'd0);
      rst = 1'b1;
      command = 4'd2;
      fp_src1 = {BOXHI, 32'h40000000};
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      checkOutput("rstValid", {63'd0, out_valid}, 64'd0);
      checkOutput("rstInt", int_result, 64'd0);
      checkOutput("rstFp", fp_result, 64'd0);
      checkOutput("rstFlag", {63'd0, flag_invalid}, 64'd0);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("rstNoGhosts", 64'(consumeCount - base), 64'd0);
      runDirected("afterRst", 4'd3, {BOXHI, 32'hBF800000}, {BOXHI, 32'h80000000}, 64'd0, 64'd0, {BOXHI, 32'h3F800000}, 1'b0);

      $display("[TB] randomized operations");
      base = acceptCount;
      doneRand = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               applyStimulus(4'($urandom_range(0, 15)), randOperand(), randOperand(), {$urandom, $urandom});
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
            end
            in_valid = 1'b0;
            doneRand = 1'b1;
         end
         begin
            while (!doneRand) begin
               @(posedge clk);
               #2 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain("randDrain");
      checkOutput("randAccepted", 64'(acceptCount - base), 64'd300);
      checkOutput("finalQueue", 64'(expQ.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
      $finish;
   end

endmodule
